// File: rtl/ct_addsub_engine.sv
// ct_addsub_engine
// Walks the DIMENSION+1 words of two ciphertexts in shared memory, combines
// each pair modulo 2^CIPHERTEXT_WIDTH (add: A+B, subtract: B-A) and writes
// the result to the destination ciphertext. Each element is read, read,
// then written, so in-place destinations are safe.
module ct_addsub_engine #(
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 2,
    parameter int DATA_WIDTH       = 128,
    parameter int ADDR_WIDTH       = 10
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,

    // Decoded command from the opcode decoder
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_src_a,
    input  logic [ADDR_WIDTH-1:0] cmd_src_b,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,

    // Shared ciphertext memory (read data valid one cycle after mem_rd_en)
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,

    // Status reflected to the host
    output logic                  busy,
    output logic                  done
);

    // Element index must be able to hold DIMENSION; keep at least one bit.
    localparam int IDX_W = (DIMENSION > 0) ? $clog2(DIMENSION + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIMENSION);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR,
        DONE
    } state_t;

    state_t                      state;
    logic [IDX_W-1:0]            idx;
    logic                        op_q;
    logic [ADDR_WIDTH-1:0]       src_a_q;
    logic [ADDR_WIDTH-1:0]       src_b_q;
    logic [ADDR_WIDTH-1:0]       dst_q;
    logic [CIPHERTEXT_WIDTH-1:0] a_reg;

    logic [IDX_W-1:0]            idx_inc;
    logic [ADDR_WIDTH-1:0]       idx_ext;
    logic [ADDR_WIDTH-1:0]       idx_inc_ext;
    logic [CIPHERTEXT_WIDTH-1:0] b_word;
    logic [CIPHERTEXT_WIDTH-1:0] result;

    assign idx_inc     = idx + IDX_W'(1);
    assign idx_ext     = ADDR_WIDTH'(idx);
    assign idx_inc_ext = ADDR_WIDTH'(idx_inc);

    // Operand B is the word returned for the RD_B read, present during WR.
    assign b_word = mem_rd_data[CIPHERTEXT_WIDTH-1:0];

    // Truncation to CIPHERTEXT_WIDTH bits is the modular reduction.
    assign result = op_q ? (b_word - a_reg) : (a_reg + b_word);

    // NOTE: write data is the only output not held in a flop because operand B
    // arrives in the WR cycle itself; gating on mem_wr_en keeps it 0 elsewhere.
    assign mem_wr_data = mem_wr_en ? DATA_WIDTH'(result) : '0;

    // Sequencer: command capture, element walk, and registered status/strobes.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            idx         <= '0;
            op_q        <= 1'b0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            a_reg       <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q        <= cmd_op;
                        src_a_q     <= cmd_src_a;
                        src_b_q     <= cmd_src_b;
                        dst_q       <= cmd_dst;
                        idx         <= '0;
                        state       <= RD_A;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= cmd_src_a;
                    end
                end

                RD_A: begin
                    state       <= RD_B;
                    mem_rd_addr <= src_b_q + idx_ext;
                end

                RD_B: begin
                    a_reg       <= mem_rd_data[CIPHERTEXT_WIDTH-1:0];
                    state       <= WR;
                    mem_rd_en   <= 1'b0;
                    mem_rd_addr <= '0;
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= dst_q + idx_ext;
                end

                WR: begin
                    mem_wr_en   <= 1'b0;
                    mem_wr_addr <= '0;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        idx         <= idx_inc;
                        state       <= RD_A;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= src_a_q + idx_inc_ext;
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    cmd_ready   <= 1'b1;
                    mem_rd_en   <= 1'b0;
                    mem_rd_addr <= '0;
                    mem_wr_en   <= 1'b0;
                    mem_wr_addr <= '0;
                end
            endcase
        end
    end

endmodule
